i2s_master_serializer: RTL and testbench

I2S_MASTER_SERIALIZER -- requirements
Module: i2s_master_serializer

---
 rtl/i2s_master_serializer.sv | 188 ++++++++++++++++++
 tb/tb_i2s_master_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_master_serializer.sv
// ---------------------------------------------------------------------------
// i2s_master_serializer
//
// I2S bus master. It generates BCLK and the word select, serialises one
// 24-bit stereo sample pair per 64-slot frame, and deserialises the pair
// returned by the slave. All logic runs on the rising edge of clk_48. Reset
// is synchronous and active-low.
//
// Parameters
//   BCLK_DIV     clk_48 cycles per BCLK half-period (>= 2)
//
// Ports
//   clk_48       in   sole clock
//   rst_n        in   synchronous active-low reset (overrides en)
//   en           in   run enable; dropping it lets the current frame finish
//   audio_l_in   in   24b left sample to send, latched at the slot-0 entry
//   audio_r_in   in   24b right sample to send, latched at the slot-0 entry
//   i2s_d_in     in   serial data from the slave
//   i2s_bclk     out  bit clock
//   i2s_lr       out  word select (0 = left, 1 = right)
//   i2s_d_out    out  serial data to the slave
//   audio_l_out  out  last received left sample
//   audio_r_out  out  last received right sample
//   new_sample   out  one-cycle pulse when audio_*_out is updated
//
// Build option
//   I2S_LOOPBACK_EN  when defined, the receive path samples the internal
//                    i2s_d_out register and i2s_d_in is ignored.
// ---------------------------------------------------------------------------
module i2s_master_serializer #(
    parameter int BCLK_DIV = 8
) (
    input  logic        clk_48,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] audio_l_in,
    input  logic [23:0] audio_r_in,
    input  logic        i2s_d_in,
    output logic        i2s_bclk,
    output logic        i2s_lr,
    output logic        i2s_d_out,
    output logic [23:0] audio_l_out,
    output logic [23:0] audio_r_out,
    output logic        new_sample
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    // ST_IDLE also covers the start-up half-periods before slot 0 is entered
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DW-1:0] r_div;
    logic [0:0]    r_state;
    logic          r_bclk;
    logic          r_lr;
    logic          r_dout;
    logic [5:0]    r_slot;
    logic [23:0]   r_l_lat;
    logic [23:0]   r_r_lat;
    logic [23:0]   r_rx_l;
    logic [23:0]   r_rx_r;
    logic          r_cap_done;
    logic [23:0]   r_l_out;
    logic [23:0]   r_r_out;
    logic          r_new;

    logic       w_tick;
    logic       w_fall;
    logic       w_rise;
    logic       w_idle;
    logic       w_start;
    logic       w_stop;
    logic [5:0] w_nslot;
    logic [4:0] w_idx;
    logic       w_tx_bit;
    logic       w_rx_bit;
    logic       w_rx_data;

    assign w_tick = (r_div == DIV_LAST);
    assign w_fall = w_tick & r_bclk;
    assign w_rise = w_tick & ~r_bclk;
    assign w_idle = ~en & (r_state == ST_IDLE);

    // A frame starts on the first falling edge after start-up, or on the
    // wrap out of slot 63 while still enabled. Without en, slot 63 ends it.
    assign w_start = w_fall & ((r_state == ST_IDLE) | ((r_slot == 6'd63) & en));
    assign w_stop  = w_fall & (r_state == ST_RUN) & (r_slot == 6'd63) & ~en;
    assign w_nslot = ((r_state == ST_IDLE) || (r_slot == 6'd63)) ? 6'd0 : r_slot + 6'd1;

    // Both halves use the same in-half offset: slot 1/33 carries bit 23,
    // slot 24/56 carries bit 0.
    assign w_idx = 5'd24 - w_nslot[4:0];

    always_comb begin
        w_tx_bit = 1'b0;
        if ((w_nslot[4:0] != 5'd0) && (w_nslot[4:0] <= 5'd24)) begin
            w_tx_bit = w_nslot[5] ? r_r_lat[w_idx] : r_l_lat[w_idx];
        end
    end

`ifdef I2S_LOOPBACK_EN
    assign w_rx_bit = r_dout;
`else
    assign w_rx_bit = i2s_d_in;
`endif

    assign w_rx_data = (r_slot[4:0] != 5'd0) && (r_slot[4:0] <= 5'd24);

    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_state    <= ST_IDLE;
            r_bclk     <= 1'b0;
            r_lr       <= 1'b1;
            r_dout     <= 1'b0;
            r_slot     <= 6'd0;
            r_l_lat    <= 24'd0;
            r_r_lat    <= 24'd0;
            r_rx_l     <= 24'd0;
            r_rx_r     <= 24'd0;
            r_cap_done <= 1'b0;
            r_l_out    <= 24'd0;
            r_r_out    <= 24'd0;
            r_new      <= 1'b0;
        end else begin
            // Output load trails the slot-56 capture by one cycle
            r_new <= 1'b0;
            if (r_cap_done) begin
                r_l_out    <= r_rx_l;
                r_r_out    <= r_rx_r;
                r_new      <= 1'b1;
                r_cap_done <= 1'b0;
            end

            if (w_idle) begin
                r_div  <= '0;
                r_bclk <= 1'b0;
                r_lr   <= 1'b1;
                r_dout <= 1'b0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_bclk <= ~r_bclk;
                end

                if (w_fall) begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                        r_slot  <= 6'd0;
                        r_lr    <= 1'b1;
                        r_dout  <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        r_slot  <= w_nslot;
                        r_lr    <= w_nslot[5];
                        r_dout  <= w_tx_bit;
                        if (w_start) begin
                            r_l_lat <= audio_l_in;
                            r_r_lat <= audio_r_in;
                        end
                    end
                end

                // The start-up rising edge precedes slot 0 and captures nothing
                if (w_rise && (r_state == ST_RUN) && w_rx_data) begin
                    if (r_slot[5]) begin
                        r_rx_r <= {r_rx_r[22:0], w_rx_bit};
                    end else begin
                        r_rx_l <= {r_rx_l[22:0], w_rx_bit};
                    end
                    if (r_slot == 6'd56) begin
                        r_cap_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign i2s_bclk    = r_bclk;
    assign i2s_lr      = r_lr;
    assign i2s_d_out   = r_dout;
    assign audio_l_out = r_l_out;
    assign audio_r_out = r_r_out;
    assign new_sample  = r_new;

endmodule

// File: tb/tb_i2s_master_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_master_serializer
//
// Reset/idle vector table, then free-running frames checked every cycle
// against a slot/frame arithmetic model (random samples and slave data,
// en drop mid-frame), then a reset asserted mid-frame.
// ---------------------------------------------------------------------------
module tb_i2s_master_serializer;

    localparam int DIV = 8;
    localparam int NF  = 8;

    logic        clk_48 = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] audio_l_in;
    logic [23:0] audio_r_in;
    logic        i2s_d_in;
    logic        i2s_bclk;
    logic        i2s_lr;
    logic        i2s_d_out;
    logic [23:0] audio_l_out;
    logic [23:0] audio_r_out;
    logic        new_sample;

    always #5 clk_48 = ~clk_48;

    i2s_master_serializer #(.BCLK_DIV(DIV)) dut (
        .clk_48     (clk_48),
        .rst_n      (rst_n),
        .en         (en),
        .audio_l_in (audio_l_in),
        .audio_r_in (audio_r_in),
        .i2s_d_in   (i2s_d_in),
        .i2s_bclk   (i2s_bclk),
        .i2s_lr     (i2s_lr),
        .i2s_d_out  (i2s_d_out),
        .audio_l_out(audio_l_out),
        .audio_r_out(audio_r_out),
        .new_sample (new_sample)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          n;        // rising clk edges since en was raised from idle
    int          n_end;    // edge at which an en-dropped frame ends
    logic [23:0] tx_l [NF];
    logic [23:0] tx_r [NF];
    logic [23:0] sl_l [NF];
    logic [23:0] sl_r [NF];
    logic [23:0] e_lout;
    logic [23:0] e_rout;
    logic        e_ns;
    logic [63:0] word0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [23:0] l;
        logic [23:0] r;
        logic        bclk;
        logic        lr;
        logic        dout;
        logic        ns;
    } vec_t;

    vec_t tbl [20];

    function automatic logic slot_bit(input logic [23:0] lw, input logic [23:0] rw, input int s);
        if (s >= 1 && s <= 24) return lw[24 - s];
        if (s >= 33 && s <= 56) return rw[56 - s];
        return 1'b0;
    endfunction

    task automatic check_all(input string nm, input logic b, input logic lr, input logic d,
                             input logic ns, input logic [23:0] lo, input logic [23:0] ro);
        checks++;
        if ({i2s_bclk, i2s_lr, i2s_d_out, new_sample, audio_l_out, audio_r_out} !== {b, lr, d, ns, lo, ro}) begin
            errors++;
            $display("FAIL %s n=%0d got bclk/lr/d/ns=%b%b%b%b l=%h r=%h want %b%b%b%b l=%h r=%h",
                     nm, n, i2s_bclk, i2s_lr, i2s_d_out, new_sample, audio_l_out, audio_r_out,
                     b, lr, d, ns, lo, ro);
        end
    endtask

    task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // One clk_48 cycle of the running bus: advance the model at the rising
    // edge, compare at the falling edge, then drive the slave data bit.
    task automatic step(input bit collect);
        int h, h1, s, f;
        logic eb, elr, ed;
        @(posedge clk_48);
        n++;
        h = n / DIV;
        if (n % DIV == 0 && h >= 2 && h % 2 == 0 && n < n_end && (h - 2) % 128 == 0) begin
            f = (h - 2) / 128;
            if (f < NF) begin
                tx_l[f] = audio_l_in;
                tx_r[f] = audio_r_in;
            end
        end
        e_ns = 1'b0;
        if (n > 1 && (n - 1) % DIV == 0 && n - 1 < n_end) begin
            h1 = (n - 1) / DIV;
            if (h1 >= 2 && (h1 - 2) % 128 == 113) begin
                f = (h1 - 2) / 128;
                e_ns = 1'b1;
`ifdef I2S_LOOPBACK_EN
                e_lout = tx_l[f];
                e_rout = tx_r[f];
`else
                e_lout = sl_l[f];
                e_rout = sl_r[f];
`endif
            end
        end
        @(negedge clk_48);
        s = 0;
        f = 0;
        if (n >= n_end) begin
            eb = 1'b0; elr = 1'b1; ed = 1'b0;
        end else if (h < 2) begin
            eb = (h % 2) == 1; elr = 1'b1; ed = 1'b0;
        end else begin
            s   = ((h - 2) / 2) % 64;
            f   = (h - 2) / 128;
            eb  = (h % 2) == 1;
            elr = (s >= 32);
            ed  = slot_bit(tx_l[f], tx_r[f], s);
        end
        check_all("run", eb, elr, ed, e_ns, e_lout, e_rout);
        if (collect && n % DIV == 0 && h >= 3 && h % 2 == 1 && (h - 2) / 128 == 0)
            word0[63 - s] = i2s_d_out;
`ifdef I2S_LOOPBACK_EN
        i2s_d_in = 1'b1;
`else
        if (n < n_end && h >= 2 && ((s >= 1 && s <= 24) || (s >= 33 && s <= 56)))
            i2s_d_in = slot_bit(sl_l[f], sl_r[f], s);
        else
            i2s_d_in = 1'($urandom);
`endif
    endtask

    initial begin
        // Reset and idle vectors; rows 10..17 show the divider restarting from 0
        tbl[0] = '{1'b0, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 24'h123456, 24'h654321, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 10; i < 17; i++)
            tbl[i] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; audio_l_in = '0; audio_r_in = '0; i2s_d_in = 1'b1;
        n = 0; n_end = 32'h3FFF_FFFF; e_lout = '0; e_rout = '0; e_ns = 1'b0; word0 = '0;
        for (int i = 0; i < NF; i++) begin
            tx_l[i] = '0; tx_r[i] = '0;
            sl_l[i] = 24'($urandom); sl_r[i] = 24'($urandom);
        end
        sl_l[0] = 24'h123456;
        sl_r[0] = 24'hFEDCBA;

        @(negedge clk_48);
        for (int i = 0; i < 20; i++) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en;
            audio_l_in = tbl[i].l; audio_r_in = tbl[i].r;
            @(posedge clk_48);
            @(negedge clk_48);
            check_all($sformatf("vec%0d", i), tbl[i].bclk, tbl[i].lr, tbl[i].dout, tbl[i].ns, 24'h0, 24'h0);
        end

        // Free-running frames from idle; en dropped in frame 3 at slot 40
        audio_l_in = 24'hA5C3F0;
        audio_r_in = 24'h800001;
        en = 1'b1;
        n = 0;
        while (n < n_end + 64) begin
            step(1'b1);
`ifndef I2S_LOOPBACK_EN
            if (n == DIV * 115 + 1) begin
                check_val("rx_left_f0", 64'(audio_l_out), 64'h123456);
                check_val("rx_right_f0", 64'(audio_r_out), 64'hFEDCBA);
            end
`endif
            if (n == DIV * 130)
                check_val("tx_frame0", word0, {1'b0, 24'hA5C3F0, 8'h00, 24'h800001, 7'h00});
            // Mid-frame input change: frame 1 keeps its latched value
            if (n == DIV * (2 + 128 + 20))
                audio_l_in = 24'h5A0F3C;
            if (n > DIV * 130 && $urandom_range(0, 99) == 0) begin
                audio_l_in = 24'($urandom);
                audio_r_in = 24'($urandom);
            end
            if (n == DIV * (2 + 128 * 3 + 80)) begin
                en = 1'b0;
                n_end = DIV * (2 + 128 * 4);
            end
        end

        // Reset asserted at slot 20 of a fresh frame, with en still high
        audio_l_in = 24'($urandom);
        audio_r_in = 24'($urandom);
        en = 1'b1;
        n = 0;
        n_end = 32'h3FFF_FFFF;
        while (n < DIV * 42) step(1'b0);
        rst_n = 1'b0;
        @(posedge clk_48);
        @(negedge clk_48);
        check_all("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
        rst_n = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk_48);
            check_all("post_rst_idle", 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
